// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player and the song ROM that feeds it.
package note_player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_DIV_BITS = 18;
  localparam int DEF_DUR_BITS = 4;

  // Half-period divisors for a 50 MHz clk (round(50e6 / (2 * f))).
  localparam logic [DEF_DIV_BITS-1:0] NOTE_REST = 18'd0;
  localparam logic [DEF_DIV_BITS-1:0] NOTE_C4   = 18'd95556;
  localparam logic [DEF_DIV_BITS-1:0] NOTE_E4   = 18'd75843;
  localparam logic [DEF_DIV_BITS-1:0] NOTE_G4   = 18'd63776;
  localparam logic [DEF_DIV_BITS-1:0] NOTE_A4   = 18'd56818;
  localparam logic [DEF_DIV_BITS-1:0] NOTE_C5   = 18'd47778;

endpackage

// File: rtl/note_player_tone_divider.sv
// Square-wave generator: reloadable half-period down-counter plus toggle flop.
module tone_divider
  import note_player_pkg::*;
#(
  parameter int DIV_BITS = DEF_DIV_BITS
) (
  input  logic                clk,
  input  logic                r,
  input  logic                run,
  input  logic [DIV_BITS-1:0] hp,
  output logic                audio
);

  logic [DIV_BITS-1:0] div_cnt_r;
  logic [DIV_BITS-1:0] reload_s;
  logic                audio_r;

  assign reload_s = hp - DIV_BITS'(1);
  assign audio    = audio_r;

  // While stopped the counter tracks hp-1 so the first toggle lands hp cycles after run rises.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      div_cnt_r <= {DIV_BITS{1'b0}};
      audio_r   <= 1'b0;
    end else if (!run) begin
      div_cnt_r <= reload_s;
      audio_r   <= 1'b0;
    end else if (hp == {DIV_BITS{1'b0}}) begin
      div_cnt_r <= div_cnt_r;
      audio_r   <= 1'b0;
    end else if (div_cnt_r == {DIV_BITS{1'b0}}) begin
      div_cnt_r <= reload_s;
      audio_r   <= ~audio_r;
    end else begin
      div_cnt_r <= div_cnt_r - DIV_BITS'(1);
      audio_r   <= audio_r;
    end
  end

endmodule

// File: rtl/note_player.sv
// Plays one note descriptor at a time: tone for N beats, a silent gap, then a note_done pulse.
module note_player
  import note_player_pkg::*;
#(
  parameter int DIV_BITS  = DEF_DIV_BITS,
  parameter int DUR_BITS  = DEF_DUR_BITS,
  parameter int GAP_TICKS = 1,
  parameter int GAP_BITS  = 2
) (
  input  logic                clk,
  input  logic                r,
  input  logic                beat_tick,
  input  logic                abort,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [DIV_BITS-1:0] note_half_period,
  input  logic [DUR_BITS-1:0] note_beats,
  output logic                audio_out,
  output logic                busy,
  output logic                note_done
);

  localparam logic [GAP_BITS-1:0] GAP_INIT = GAP_BITS'(GAP_TICKS);
  localparam bit                  HAS_GAP  = (GAP_TICKS != 32'sd0);

  state_t              state_r;
  logic [DIV_BITS-1:0] hp_r;
  logic [DUR_BITS-1:0] beats_left_r;
  logic [GAP_BITS-1:0] gap_cnt_r;
  logic                ready_r;
  logic                busy_r;
  logic                done_r;

  logic [DIV_BITS-1:0] hp_sel_s;
  logic                last_beat_s;
  logic                run_s;

  function automatic logic [DUR_BITS-1:0] norm_beats(input logic [DUR_BITS-1:0] b);
    if (b == {DUR_BITS{1'b0}}) norm_beats = DUR_BITS'(1);
    else                       norm_beats = b;
  endfunction

  // The divider preloads from the live descriptor in IDLE; a note end or abort silences it on the same edge.
  always_comb begin
    hp_sel_s    = hp_r;
    last_beat_s = 1'b0;
    run_s       = 1'b0;
    if (state_r == IDLE) hp_sel_s = note_half_period;
    else                 hp_sel_s = hp_r;
    if (beat_tick && (beats_left_r == DUR_BITS'(1))) last_beat_s = 1'b1;
    else                                             last_beat_s = 1'b0;
    if ((state_r == PLAY) && !abort && !last_beat_s) run_s = 1'b1;
    else                                             run_s = 1'b0;
  end

  tone_divider #(.DIV_BITS(DIV_BITS)) u_div (
    .clk   (clk),
    .r     (r),
    .run   (run_s),
    .hp    (hp_sel_s),
    .audio (audio_out)
  );

  // Control FSM with beat and gap counters; ready/busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_r      <= IDLE;
      hp_r         <= {DIV_BITS{1'b0}};
      beats_left_r <= {DUR_BITS{1'b0}};
      gap_cnt_r    <= {GAP_BITS{1'b0}};
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (note_valid) begin
            hp_r         <= note_half_period;
            beats_left_r <= norm_beats(note_beats);
            state_r      <= PLAY;
            ready_r      <= 1'b0;
            busy_r       <= 1'b1;
          end
        end
        PLAY: begin
          if (abort) begin
            state_r      <= IDLE;
            hp_r         <= {DIV_BITS{1'b0}};
            beats_left_r <= {DUR_BITS{1'b0}};
            gap_cnt_r    <= {GAP_BITS{1'b0}};
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
          end else if (last_beat_s) begin
            beats_left_r <= {DUR_BITS{1'b0}};
            if (HAS_GAP) begin
              state_r   <= GAP;
              gap_cnt_r <= GAP_INIT;
            end else begin
              state_r <= IDLE;
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else if (beat_tick) begin
            beats_left_r <= beats_left_r - DUR_BITS'(1);
          end
        end
        GAP: begin
          if (abort) begin
            state_r      <= IDLE;
            hp_r         <= {DIV_BITS{1'b0}};
            beats_left_r <= {DUR_BITS{1'b0}};
            gap_cnt_r    <= {GAP_BITS{1'b0}};
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
          end else if (beat_tick) begin
            if (gap_cnt_r <= GAP_BITS'(1)) begin
              state_r   <= IDLE;
              gap_cnt_r <= {GAP_BITS{1'b0}};
              ready_r   <= 1'b1;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              gap_cnt_r <= gap_cnt_r - GAP_BITS'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign note_ready = ready_r;
  assign busy       = busy_r;
  assign note_done  = done_r;

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Consumes one note descriptor per handshake: half-period divisor plus duration in beats.
- Drives a square-wave audio output at the note pitch by down-counting clk cycles.
- Measures note length by counting beat_tick strobes, which come from the beat counter's carry-out.
- Inserts a silent gap after each note, then pulses note_done. Sits between the song ROM sequencer (producer) and the buzzer pin.

Parameters:
- DIV_BITS, 18, width of half-period divisor in clk cycles
- DUR_BITS, 4, width of note duration in beats
- GAP_TICKS, 1, silent beat_ticks after each note (0 = no gap)
- GAP_BITS, 2, width of gap counter; must hold GAP_TICKS

Ports:
- clk  in  1  system clock, rising edge
- r  in  1  reset, asynchronous, active-high
- beat_tick  in  1  one-cycle beat strobe
- abort  in  1  synchronous stop request
- note_valid  in  1  descriptor valid
- note_ready  out  1  block can accept a descriptor
- note_half_period  in  DIV_BITS  clk cycles per audio half-period; 0 = rest
- note_beats  in  DUR_BITS  duration in beats; 0 treated as 1
- audio_out  out  1  square-wave output
- busy  out  1  high in PLAY or GAP
- note_done  out  1  one-cycle pulse at note completion

Behaviour:
- Reset is asynchronous and active-high on r; clock is clk.
- Reset values:
  - state IDLE
  - audio_out 0, note_done 0, busy 0
  - all counters 0
  - note_ready 1, because it is decoded from IDLE and so is high during and after reset.
- States: IDLE, PLAY, GAP.
  - note_ready = (state==IDLE).
  - busy = (state!=IDLE).
- IDLE, on note_valid && note_ready at a clk edge:
  - latch hp = note_half_period
  - beats_left = max(note_beats, 1)
  - div_cnt = hp-1
  - audio_out = 0
  - go to PLAY
  - A beat_tick in the acceptance cycle is ignored.
- PLAY, pitch generation:
  - If hp!=0: div_cnt decrements each cycle. When div_cnt==0, toggle audio_out and reload hp-1.
  - First toggle occurs hp cycles after the acceptance edge. Output period is 2*hp cycles; hp=1 toggles every cycle.
  - If hp==0 (rest): audio_out held 0 and div_cnt frozen.
- PLAY, beat counting:
  - Each beat_tick decrements beats_left.
  - beat_tick with beats_left==1 ends the note: audio_out forced 0 on that edge.
  - Then, if GAP_TICKS==0: go to IDLE with note_done=1 for the next cycle.
  - Otherwise: go to GAP with gap_cnt = GAP_TICKS.
- GAP:
  - audio_out 0.
  - Each beat_tick decrements gap_cnt. The tick with gap_cnt==1 moves to IDLE and sets note_done=1 for exactly one cycle.
- note_done timing: registered, high during the first IDLE cycle. A new note may be accepted in that same cycle.
- abort (synchronous), in PLAY or GAP: next edge goes to IDLE, audio_out 0, counters cleared, note_done NOT pulsed.
  - abort in IDLE has no effect and does not block acceptance.
  - If abort and a note completion coincide, abort wins: no note_done.
- beat_tick and a divider toggle in the same cycle: the beat end wins, so audio_out goes to 0 and is not toggled.
- Descriptor inputs are sampled only at the acceptance edge. Changes while busy are ignored.
- Reset asserted mid-note: immediate return to reset values, no note_done.
- Arithmetic:
  - Counters are unsigned, no wrap-around used.
  - beats_left never decrements below 1 in PLAY.
  - div_cnt reload is hp-1 computed at DIV_BITS width.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, PLAY=2'd1, GAP=2'd2
  - default DIV_BITS/DUR_BITS
  - note divisor constants for the song ROM
- One natural sub-module: tone_divider.
  - Ports: clk, r, run, hp, audio.
  - Contains the reloadable down-counter and toggle flop; forced to 0 when run=0 or hp=0.
- Top holds the FSM, beat and gap counters.

Test Plan:
- Reset/idle:
  - Stimulus: assert r mid-simulation while in PLAY.
  - Response: audio_out, busy, note_done go to 0 immediately; note_ready=1 the same time.
- Basic note:
  - Stimulus: hp=3, beats=2, GAP_TICKS=1, beat_tick every 40 cycles.
  - Response: audio_out toggles every 3 cycles (period 6) until the 2nd tick; low for one gap tick; note_done high one cycle; note_ready back to 1.
- Rest and zero beats:
  - Stimulus: hp=0, beats=0.
  - Response: audio_out stays 0; note ends on the 1st beat_tick; note_done after the gap tick.
- Back-to-back:
  - Stimulus: note_valid held high with a second descriptor (hp=5).
  - Response: accepted in the note_done cycle; the new tone's first toggle 5 cycles later.
- Abort:
  - Stimulus: abort pulse during PLAY at beats_left=3.
  - Response: IDLE next cycle, audio_out 0, no note_done, note_ready=1.
- Coincidence:
  - Stimulus: beat_tick on the final beat in the same cycle as a divider toggle.
  - Response: audio_out=0, no toggle; gap entered.
